// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong reorder buffer: collects N = 2^LOG_N coefficients per frame and replays them
// in bit-reversed (or natural) order while the other bank fills.
module ntt_bitrev_reorder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LOG_N  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              rev_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              frame_err
);

  localparam int unsigned N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] CntLast = {LOG_N{1'b1}};
  localparam logic [LOG_N-1:0] CntZero = '0;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] r;
    for (int unsigned i = 0; i < LOG_N; i++) begin
      r[i] = v[LOG_N-1-i];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem_q [2][N];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG_N-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG_N-1:0]  rd_cnt_q, rd_cnt_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        mode_q, mode_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              frame_err_q, frame_err_d;

  logic             wr_fire, wr_wrap;
  logic             rd_load, rd_wrap;
  logic [LOG_N-1:0] rd_addr;

  always_comb begin
    s_ready = !full_q[wr_bank_q];
    wr_fire = s_valid && s_ready;
    wr_wrap = (wr_cnt_q == CntLast);
    rd_load = full_q[rd_bank_q] && (!m_valid_q || m_ready);
    rd_wrap = (rd_cnt_q == CntLast);
    rd_addr = mode_q[rd_bank_q] ? bitrev(rd_cnt_q) : rd_cnt_q;

    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    full_d      = full_q;
    mode_d      = mode_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    frame_err_d = frame_err_q;

    if (wr_fire) begin
      if (wr_cnt_q == CntZero) begin
        mode_d[wr_bank_q] = rev_en;
      end
      // The internal count defines the frame boundary; s_last is only cross-checked.
      if (s_last != wr_wrap) begin
        frame_err_d = 1'b1;
      end
      if (wr_wrap) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + LOG_N'(1);
      end
    end

    // A clear here targets the read bank; a set above targets the write bank, and the
    // same bank can never be both full and empty, so the two updates never collide.
    if (rd_load) begin
      m_data_d  = mem_q[rd_bank_q][rd_addr];
      m_valid_d = 1'b1;
      m_last_d  = rd_wrap;
      if (rd_wrap) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + LOG_N'(1);
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      full_q      <= '0;
      mode_q      <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      mode_q      <= mode_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Bank storage is left unreset; the full flags guard against reading stale words.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_cnt_q] <= s_data;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_data    = m_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/ntt_bitrev_reorder.md
Name: ntt_bitrev_reorder

Overview:
Streaming bit-reversal reorder buffer for the NTT datapath. Accepts frames of N = 2^LOG_N coefficients in natural order and emits each frame with element index i sent to output position bitrev_LOG_N(i). Ping-pong banking sustains one coefficient per cycle. Per-frame mode selects bit-reversed or natural-order pass-through. Sits between the coefficient loader and the butterfly pipeline.

Parameters:
DATA_W, 8, coefficient width in bits
LOG_N, 3, log2 of frame length; N = 2^LOG_N; legal range 1..12

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  synchronous, active-high reset
s_valid  input  1  input coefficient valid
s_ready  output  1  buffer can accept a coefficient
s_data  input  DATA_W  input coefficient, natural order
s_last  input  1  producer marks final coefficient of frame (checked only)
rev_en  input  1  1 = bit-reversed output, 0 = natural order; sampled on first beat of frame
m_valid  output  1  output coefficient valid
m_ready  input  1  consumer accepts output
m_data  output  DATA_W  output coefficient
m_last  output  1  high with final coefficient of each output frame
frame_err  output  1  sticky: s_last disagreed with internal count

Behaviour:
- Storage: two banks of N x DATA_W. wr_bank, rd_bank pointers (1 bit). wr_cnt, rd_cnt (LOG_N bits). full[1:0] flags. mode[1:0] per-bank latched rev_en.
- Reset (rst=1 at edge): wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full=0, m_valid=0, m_last=0, m_data=0, frame_err=0. Bank contents need not clear. Reset mid-frame discards every partial and stored frame. s_ready=1 in the first cycle after reset.
- s_ready = !full[wr_bank] (combinational, no dependency on s_valid).
- Write beat (s_valid & s_ready): mem[wr_bank][wr_cnt] <= s_data. If wr_cnt==0, mode[wr_bank] <= rev_en. If wr_cnt==N-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0. Otherwise wr_cnt increments.
- s_last check on each write beat: if s_last != (wr_cnt==N-1), frame_err<=1. It stays set until rst. The frame boundary is always the internal count; s_last never alters it.
- Read address: mode[rd_bank] ? bitrev(rd_cnt) : rd_cnt. bitrev mirrors the LOG_N bits.
- Output register load when full[rd_bank] & (!m_valid | m_ready):
  - m_data <= mem[rd_bank][addr], m_valid<=1, m_last <= (rd_cnt==N-1).
  - If rd_cnt==N-1: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0. Otherwise rd_cnt increments.
- If there is no load and m_ready=1, then m_valid<=0.
- If m_valid=1 and m_ready=0, m_data, m_valid and m_last hold stable.
- Latency: the Nth write beat is accepted at edge k, and m_valid rises at edge k+1 with the first output word. full is read at its registered value, so no same-cycle bypass.
- Throughput: 1 word/cycle sustained with m_ready=1 and back-to-back frames. Writes to bank A while bank B drains.
- Both banks full: s_ready=0 until the drained bank's last word loads into the output register. s_ready=1 in the next cycle.
- A full-set on one bank and a full-clear on the other in the same edge are independent and both take effect.
- Same-bank set and clear cannot coincide; clear requires full=1, set requires full=0.
- LOG_N=1 degenerates correctly: bitrev is the identity.

Test Plan:
- N=8, DATA_W=8, rev_en=1, input 0..7 with s_last on the 8th word, m_ready=1 -> output 0,4,2,6,1,5,3,7; m_last only on 7; m_valid rises the cycle after the 8th accept; frame_err=0.
- Three back-to-back frames (0..7, 8..15, 16..23), s_valid and m_ready held 1 -> s_ready never drops; output is 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15,16,… with no bubbles.
- Frame 1 rev_en=1, frame 2 rev_en=0, rev_en toggling mid-frame -> frame 1 reversed, frame 2 natural 8..15; mid-frame toggles are ignored.
- m_ready=0 for 20 cycles while 2 frames are input -> s_ready=0 after the 16th accept; m_data=0 held stable. Releasing m_ready gives 16 correct outputs, and s_ready returns the cycle after the 8th output loads.
- s_last asserted on the 5th word -> frame_err=1 and sticky; the frame still completes on the 8th word with correct order.
- rst pulsed after 5 writes and after 3 outputs of a prior frame -> m_valid=0 next cycle, s_ready=1. A fresh frame 0..7 then outputs exactly 0,4,2,6,1,5,3,7 with no stale data.
